// File: rtl/lm75a_pkg.sv
// lm75a_pkg: shared types and constants for the LM75A I2C target emulation.
// Contents: FSM state encoding, register pointer values, register reset
// defaults, and helpers that build the 16-bit read word and pick one bit of it.
`timescale 1ns/1ps
package lm75a_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    localparam logic [1:0] PTR_TEMP  = 2'd0;
    localparam logic [1:0] PTR_CONF  = 2'd1;
    localparam logic [1:0] PTR_THYST = 2'd2;
    localparam logic [1:0] PTR_TOS   = 2'd3;

    localparam logic [7:0] CONF_RST  = 8'h00;
    localparam logic [8:0] THYST_RST = 9'h096;  // 75 C
    localparam logic [8:0] TOS_RST   = 9'h0A0;  // 80 C

    // Left-justified 16-bit image of the register selected by the pointer.
    function automatic logic [15:0] tx_word(input logic [1:0]  ptr,
                                            input logic [10:0] temp,
                                            input logic [7:0]  conf,
                                            input logic [8:0]  thyst,
                                            input logic [8:0]  tos);
        logic [15:0] w;
        case (ptr)
            PTR_TEMP:  w = {temp, 5'b00000};
            PTR_CONF:  w = {conf, conf};
            PTR_THYST: w = {thyst, 7'b0000000};
            PTR_TOS:   w = {tos, 7'b0000000};
            default:   w = 16'h0000;
        endcase
        return w;
    endfunction

    // Bit idx (0 = MSB first on the wire) of the high (lsb_byte=0) or low byte.
    function automatic logic tx_bit(input logic [15:0] word,
                                    input logic        lsb_byte,
                                    input logic [2:0]  idx);
        logic [7:0] b;
        b = lsb_byte ? word[7:0] : word[15:8];
        return b[3'd7 - idx];
    endfunction

endpackage

// File: rtl/lm75a_i2c_target_sync.sv
// i2c_bus_sync: synchronises SCL/SDA into the clk domain and derives
// single-clk event pulses from the synchronised values.
// Ports: clk, rst_n (async active-low), scl_in, sda_in (raw bus levels);
//        sda_s (synchronised SDA), scl_rise, scl_fall, start_det, stop_det.
`timescale 1ns/1ps
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_prev_q, sda_prev_d;
    logic scl_now_s;

    // Shift chains and one-clk-delayed copies for edge detection.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_sync_q[SYNC_STAGES-1];
        sda_prev_d = sda_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser flops; reset to the idle (pulled-up) bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_now_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_now_s & ~scl_prev_q;
    assign scl_fall  = ~scl_now_s & scl_prev_q;
    // SDA moving while SCL is stably high marks a bus condition.
    assign start_det = scl_now_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_now_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/lm75a_i2c_target.sv
// lm75a_i2c_target: I2C target emulating an LM75A temperature sensor.
// Ports: clk, rst_n (async active-low); i2c_scl (sampled only); i2c_sda
//        (open drain, driven 0 or z); temp_in (11-bit, 0.125 C/LSB);
//        conf_reg / thyst_reg / tos_reg (register contents); busy.
`timescale 1ns/1ps
module lm75a_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    input  logic [10:0] temp_in,
    output logic [7:0]  conf_reg,
    output logic [8:0]  thyst_reg,
    output logic [8:0]  tos_reg,
    output logic        busy
);
    import lm75a_pkg::*;

    logic sda_s, scl_rise_s, scl_fall_s, start_det_s, stop_det_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (i2c_scl),
        .sda_in    (i2c_sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s)
    );

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        phase_q, phase_d;        // ACK slot: 0 = not yet driven / master ACK not seen
    logic        rw_q, rw_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        byte_idx_q, byte_idx_d;  // write side: 0 = MSB expected next
    logic [7:0]  msb_buf_q, msb_buf_d;
    logic [15:0] tx_q, tx_d;
    logic        rd_byte_q, rd_byte_d;    // read side: 0 = sending MSB
    logic        sda_oe_q, sda_oe_d;
    logic [7:0]  conf_q, conf_d;
    logic [8:0]  thyst_q, thyst_d;
    logic [8:0]  tos_q, tos_d;
    logic        busy_q, busy_d;

    logic [7:0]  byte_in_s;
    logic        byte_done_s, addr_match_s;

    assign byte_in_s    = {shift_q[6:0], sda_s};
    assign byte_done_s  = scl_rise_s && (bit_cnt_q == 3'd7);
    assign addr_match_s = (byte_in_s[7:1] == DEV_ADDR);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= PTR_TEMP;
            byte_idx_q <= 1'b0;
            msb_buf_q  <= 8'h00;
            tx_q       <= 16'h0000;
            rd_byte_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            conf_q     <= CONF_RST;
            thyst_q    <= THYST_RST;
            tos_q      <= TOS_RST;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            byte_idx_q <= byte_idx_d;
            msb_buf_q  <= msb_buf_d;
            tx_q       <= tx_d;
            rd_byte_q  <= rd_byte_d;
            sda_oe_q   <= sda_oe_d;
            conf_q     <= conf_d;
            thyst_q    <= thyst_d;
            tos_q      <= tos_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; bus conditions take priority over SCL edges.
    always_comb begin
        state_d = state_q;
        if (start_det_s) begin
            state_d = ADDR;
        end else if (stop_det_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = IDLE;
                ADDR:      state_d = byte_done_s ? (addr_match_s ? ADDR_ACK : IGNORE) : ADDR;
                ADDR_ACK:  state_d = (scl_fall_s && phase_q) ? (rw_q ? RDATA : PTR) : ADDR_ACK;
                PTR:       state_d = byte_done_s ? PTR_ACK : PTR;
                PTR_ACK:   state_d = (scl_fall_s && phase_q) ? WDATA : PTR_ACK;
                WDATA:     state_d = byte_done_s ? WDATA_ACK : WDATA;
                WDATA_ACK: state_d = (scl_fall_s && phase_q) ? WDATA : WDATA_ACK;
                RDATA:     state_d = (scl_fall_s && bit_cnt_q == 3'd7) ? RDATA_ACK : RDATA;
                RDATA_ACK: begin
                    if (scl_rise_s && sda_s) begin
                        state_d = IGNORE;
                    end else if (scl_fall_s && phase_q) begin
                        state_d = RDATA;
                    end else begin
                        state_d = RDATA_ACK;
                    end
                end
                IGNORE:    state_d = IGNORE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Datapath / output next values: shifting, ACK drive, commits, read bits.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        byte_idx_d = byte_idx_q;
        msb_buf_d  = msb_buf_q;
        tx_d       = tx_q;
        rd_byte_d  = rd_byte_q;
        sda_oe_d   = sda_oe_q;
        conf_d     = conf_q;
        thyst_d    = thyst_q;
        tos_d      = tos_q;
        busy_d     = busy_q;
        if (start_det_s) begin
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else if (stop_det_s) begin
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise_s) begin
                        shift_d   = byte_in_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = 1'b0;
                        if (bit_cnt_q == 3'd7 && state_q == ADDR) begin
                            busy_d    = addr_match_s;
                            rw_d      = byte_in_s[0];
                            // Snapshot here so MSB and LSB are coherent.
                            tx_d      = tx_word(ptr_q, temp_in, conf_q, thyst_q, tos_q);
                            rd_byte_d = 1'b0;
                        end else if (bit_cnt_q == 3'd7 && state_q == PTR) begin
                            ptr_d = byte_in_s[1:0];
                        end else begin
                            ptr_d = ptr_q;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall_s && !phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                        if (state_q == WDATA_ACK) begin
                            byte_idx_d = ~byte_idx_q;
                            case (ptr_q)
                                PTR_CONF:  conf_d = shift_q;
                                PTR_THYST: begin
                                    if (byte_idx_q) thyst_d = {msb_buf_q, shift_q[7]};
                                    else            msb_buf_d = shift_q;
                                end
                                PTR_TOS: begin
                                    if (byte_idx_q) tos_d = {msb_buf_q, shift_q[7]};
                                    else            msb_buf_d = shift_q;
                                end
                                default: msb_buf_d = msb_buf_q;  // temp writes are discarded
                            endcase
                        end else begin
                            byte_idx_d = byte_idx_q;
                        end
                    end else if (scl_fall_s) begin
                        // End of ACK slot: release, or put out the first read bit.
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (state_q == PTR_ACK) byte_idx_d = 1'b0;
                        else                    byte_idx_d = byte_idx_q;
                        sda_oe_d  = (state_q == ADDR_ACK && rw_q) ? ~tx_bit(tx_q, 1'b0, 3'd0) : 1'b0;
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                RDATA: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = 1'b0;
                        if (bit_cnt_q == 3'd7) sda_oe_d = 1'b0;
                        else                   sda_oe_d = ~tx_bit(tx_q, rd_byte_q, bit_cnt_q + 3'd1);
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_s) busy_d  = 1'b0;  // master NACK ends the read
                        else       phase_d = 1'b1;
                    end else if (scl_fall_s && phase_q) begin
                        rd_byte_d = ~rd_byte_q;
                        bit_cnt_d = 3'd0;
                        phase_d   = 1'b0;
                        sda_oe_d  = ~tx_bit(tx_q, ~rd_byte_q, 3'd0);
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                default: sda_oe_d = 1'b0;  // IDLE / IGNORE never drive
            endcase
        end
    end

    assign i2c_sda   = sda_oe_q ? 1'b0 : 1'bz;
    assign conf_reg  = conf_q;
    assign thyst_reg = thyst_q;
    assign tos_reg   = tos_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lm75a_i2c_target.sv
// Bench for lm75a_i2c_target: a bit-banged I2C master drives directed
// transactions; expected values go into a queue when stimulus is issued and
// a monitor process compares them against observed bus/register values.
`timescale 1ns/1ps
module tb_lm75a_i2c_target;

    localparam time TQ = 100ns;  // quarter SCL period (SCL = 2.5 MHz, clk = 50 MHz)

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        m_drive_low;
    logic [10:0] temp_in;
    wire         i2c_sda;
    wire  [7:0]  conf_reg;
    wire  [8:0]  thyst_reg;
    wire  [8:0]  tos_reg;
    wire         busy;

    assign i2c_sda = m_drive_low ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    always #10 clk = ~clk;

    lm75a_i2c_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2c_scl   (scl),
        .i2c_sda   (i2c_sda),
        .temp_in   (temp_in),
        .conf_reg  (conf_reg),
        .thyst_reg (thyst_reg),
        .tos_reg   (tos_reg),
        .busy      (busy)
    );

    // Scoreboard
    string       exp_name_q[$];
    logic [15:0] exp_val_q[$];
    logic [15:0] act_q[$];
    event        obs_ev;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic expect_v(input string name, input logic [15:0] v);
        exp_name_q.push_back(name);
        exp_val_q.push_back(v);
    endtask

    task automatic observe(input logic [15:0] v);
        act_q.push_back(v);
        -> obs_ev;
    endtask

    task automatic check_now(input string name, input logic [15:0] exp_v, input logic [15:0] act_v);
        expect_v(name, exp_v);
        observe(act_v);
    endtask

    // Monitor: pairs each observation with the oldest outstanding expectation.
    initial begin
        logic [15:0] a, e;
        string       n;
        forever begin
            @(obs_ev);
            while (act_q.size() != 0) begin
                a = act_q.pop_front();
                n_tests++;
                if (exp_val_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_obs: got %h, no expectation queued", a);
                end else begin
                    e = exp_val_q.pop_front();
                    n = exp_name_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL %s: got %h, expected %h", n, a, e);
                    end
                end
            end
        end
    end

    // I2C master primitives; SCL is low on entry/exit except after stop.
    task automatic bit_cycle(input logic b, output logic s);
        #TQ; m_drive_low = ~b;
        #TQ; scl = 1'b1;
        #TQ; s = i2c_sda;
        #TQ; scl = 1'b0;
    endtask

    task automatic start_c;
        #TQ; m_drive_low = 1'b0;
        #TQ; scl = 1'b1;
        #(2*TQ); m_drive_low = 1'b1;
        #(2*TQ); scl = 1'b0;
    endtask

    task automatic stop_c;
        #TQ; m_drive_low = 1'b1;
        #TQ; scl = 1'b1;
        #(2*TQ); m_drive_low = 1'b0;
        #(2*TQ);
    endtask

    task automatic wr(input string name, input logic [7:0] b, input logic exp_ack);
        logic s;
        expect_v(name, {15'd0, exp_ack});
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        observe({15'd0, s});
    endtask

    task automatic rd(input string name, input logic [7:0] exp_b, input logic nack);
        logic       s;
        logic [7:0] d;
        expect_v(name, {8'd0, exp_b});
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(nack, s);
        observe({8'd0, d});
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; scl = 1'b1; m_drive_low = 1'b0; temp_in = 11'h0C8;
        #(2*TQ); rst_n = 1'b1; #TQ;

        // Reset state
        check_now("rst_sda",   16'h0001, {15'd0, i2c_sda});
        check_now("rst_conf",  16'h0000, {8'd0, conf_reg});
        check_now("rst_thyst", 16'h0096, {7'd0, thyst_reg});
        check_now("rst_tos",   16'h00A0, {7'd0, tos_reg});
        check_now("rst_busy",  16'h0000, {15'd0, busy});

        // 1: pointer 0, repeated-start read of 25 C
        start_c; wr("t1_addr_w", 8'h90, 1'b0); wr("t1_ptr", 8'h00, 1'b0);
        start_c; wr("t1_addr_r", 8'h91, 1'b0);
        check_now("t1_busy_on", 16'h0001, {15'd0, busy});
        rd("t1_msb", 8'h19, 1'b0); rd("t1_lsb", 8'h00, 1'b1);
        stop_c; #TQ;
        check_now("t1_busy_off", 16'h0000, {15'd0, busy});

        // 2: TOS full write, then partial write discarded
        start_c; wr("t2_addr", 8'h90, 1'b0); wr("t2_ptr", 8'h03, 1'b0);
        wr("t2_msb", 8'h5A, 1'b0); wr("t2_lsb", 8'h80, 1'b0); stop_c;
        check_now("t2_tos", 16'h00B5, {7'd0, tos_reg});
        start_c; wr("t2b_addr", 8'h90, 1'b0); wr("t2b_ptr", 8'h03, 1'b0);
        wr("t2b_msb", 8'h11, 1'b0); stop_c;
        check_now("t2b_tos_kept", 16'h00B5, {7'd0, tos_reg});

        // 3: wrong address ignored, then a matching read of TOS via persisted pointer
        start_c; wr("t3_bad_addr", 8'h92, 1'b1);
        check_now("t3_busy", 16'h0000, {15'd0, busy});
        wr("t3_bad_data", 8'h00, 1'b1); stop_c;
        start_c; wr("t3_addr_r", 8'h91, 1'b0);
        rd("t3_msb", 8'h5A, 1'b0); rd("t3_lsb", 8'h80, 1'b1); stop_c;

        // 5: temperature snapshot coherence across the two bytes
        temp_in = 11'h0CF;
        start_c; wr("t5_addr_w", 8'h90, 1'b0); wr("t5_ptr", 8'h00, 1'b0);
        start_c; wr("t5_addr_r", 8'h91, 1'b0);
        rd("t5_msb", 8'h19, 1'b0);
        temp_in = 11'h0C0;
        rd("t5_lsb", 8'hE0, 1'b1); stop_c;

        // 6: THYST write, then reset while the target drives a 0 data bit
        start_c; wr("t6_addr", 8'h90, 1'b0); wr("t6_ptr", 8'h02, 1'b0);
        wr("t6_msb", 8'h10, 1'b0); wr("t6_lsb", 8'h00, 1'b0); stop_c;
        check_now("t6_thyst", 16'h0020, {7'd0, thyst_reg});
        start_c; wr("t6_addr_r", 8'h91, 1'b0);
        #TQ;
        check_now("t6_sda_driven", 16'h0000, {15'd0, i2c_sda});
        rst_n = 1'b0; #1;
        check_now("t6_sda_released", 16'h0001, {15'd0, i2c_sda});
        check_now("t6_thyst_rst", 16'h0096, {7'd0, thyst_reg});
        check_now("t6_tos_rst",   16'h00A0, {7'd0, tos_reg});
        check_now("t6_busy_rst",  16'h0000, {15'd0, busy});
        #TQ; rst_n = 1'b1; stop_c;

        // 4: read after reset uses pointer 0; config write and 3-byte read
        temp_in = 11'h7FC;
        start_c; wr("t4_addr_r", 8'h91, 1'b0);
        rd("t4_msb", 8'hFF, 1'b0); rd("t4_lsb", 8'h80, 1'b1); stop_c;
        start_c; wr("t4_addr_w", 8'h90, 1'b0); wr("t4_ptr", 8'h01, 1'b0);
        wr("t4_conf_data", 8'h06, 1'b0); stop_c;
        check_now("t4_conf", 16'h0006, {8'd0, conf_reg});
        start_c; wr("t4_addr_r2", 8'h91, 1'b0);
        rd("t4_c0", 8'h06, 1'b0); rd("t4_c1", 8'h06, 1'b0); rd("t4_c2", 8'h06, 1'b1);
        stop_c; #TQ;
        check_now("t4_busy_off", 16'h0000, {15'd0, busy});

        #TQ;
        if (exp_val_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover_expectations: got %0d pending, expected 0", exp_val_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
